// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store sequencer.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_t;

    // Halves need an even offset, words a zero offset; bytes are always aligned.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: is_aligned = ~offset[0];
            F3_W:        is_aligned = (offset == 2'b00);
            default:     is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_sh;

    assign w_sh = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_be      = 4'b0000;
        o_wdata   = 32'h0;
        o_ld_data = 32'h0;
        case (i_funct3)
            F3_B: begin
                o_be      = 4'b0001 << i_offset;
                o_wdata   = {4{i_st_data[7:0]}};
                o_ld_data = {{24{w_sh[7]}}, w_sh[7:0]};
            end
            F3_H: begin
                o_be      = 4'b0011 << i_offset;
                o_wdata   = {2{i_st_data[15:0]}};
                o_ld_data = {{16{w_sh[15]}}, w_sh[15:0]};
            end
            F3_W: begin
                o_be      = 4'b1111;
                o_wdata   = i_st_data;
                o_ld_data = i_rdata;
            end
            F3_BU:   o_ld_data = {24'h0, w_sh[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_sh[15:0]};
            default: o_ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one memory op at a time, registered outputs, bounded waits.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_inst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_misalign,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        r_state, w_nxt;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [31:0]       r_cnt;
    logic              r_req_ready, r_stall, r_mem_req, r_resp_valid;
    logic              r_mem_we, r_resp_mis, r_resp_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata, r_resp_data;

    logic              w_accept, w_cap_rd, w_to_fire, w_to;
    logic              w_is_load, w_is_store, w_mem_op, w_f3_ok, w_legal;
    logic [2:0]        w_f3;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_ld;
    logic              w_unused;

    assign w_unused   = ^{req_inst[31:15], req_inst[11:7]};
    assign w_is_load  = (req_inst[6:0] == OPC_LOAD);
    assign w_is_store = (req_inst[6:0] == OPC_STORE);
    assign w_mem_op   = w_is_load | w_is_store;

    always_comb begin
        case (req_inst[14:12])
            F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
            F3_BU, F3_HU:     w_f3_ok = w_is_load;
            default:          w_f3_ok = 1'b0;
        endcase
    end

    assign w_legal = w_f3_ok & is_aligned(req_inst[14:12], req_addr[1:0]);

    // Live request fields steer the lanes at accept; captured fields afterwards.
    assign w_f3  = (r_state == IDLE) ? req_inst[14:12] : r_f3;
    assign w_off = (r_state == IDLE) ? req_addr[1:0]   : r_off;

    lsu_align u_align (
        .i_funct3  (w_f3),
        .i_offset  (w_off),
        .i_st_data (req_wdata),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld)
    );

    assign w_to = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_state;
        w_accept  = 1'b0;
        w_cap_rd  = 1'b0;
        w_to_fire = 1'b0;
        case (r_state)
            IDLE: if (req_valid) begin
                w_accept = 1'b1;
                w_nxt    = (w_mem_op && w_legal) ? REQ : RESP;
            end
            REQ: begin
                if (mem_gnt) begin
                    if (r_mem_we) begin
                        w_nxt = RESP;
                    end else if (mem_rvalid) begin
                        w_nxt    = RESP;
                        w_cap_rd = 1'b1;
                    end else begin
                        w_nxt = WAIT;
                    end
                end else if (w_to) begin
                    w_nxt     = RESP;
                    w_to_fire = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_nxt    = RESP;
                    w_cap_rd = 1'b1;
                end else if (w_to) begin
                    w_nxt     = RESP;
                    w_to_fire = 1'b1;
                end
            end
            RESP:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_f3         <= '0;
            r_off        <= '0;
            r_req_ready  <= 1'b1;
            r_stall      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_resp_data  <= '0;
            r_resp_mis   <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_req_ready  <= (w_nxt == IDLE);
            r_stall      <= (w_nxt != IDLE);
            r_mem_req    <= (w_nxt == REQ);
            r_resp_valid <= (w_nxt == RESP);

            if (w_nxt != r_state && (w_nxt == REQ || w_nxt == WAIT))
                r_cnt <= '0;
            else if (r_state == REQ || r_state == WAIT)
                r_cnt <= r_cnt + 32'd1;

            if (w_accept) begin
                r_f3        <= req_inst[14:12];
                r_off       <= req_addr[1:0];
                r_resp_data <= '0;
                r_resp_err  <= 1'b0;
                r_resp_mis  <= w_mem_op & ~w_legal;
                if (w_mem_op && w_legal) begin
                    r_mem_we    <= w_is_store;
                    r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    r_mem_be    <= w_is_store ? w_be : 4'b0000;
                    r_mem_wdata <= w_is_store ? w_wdata : 32'h0;
                end
            end
            if (w_cap_rd)  r_resp_data <= w_ld;
            if (w_to_fire) r_resp_err  <= 1'b1;
            // Response fields are only meaningful alongside resp_valid.
            if (r_state == RESP) begin
                r_resp_data <= '0;
                r_resp_mis  <= 1'b0;
                r_resp_err  <= 1'b0;
            end
        end
    end

    assign req_ready     = r_req_ready;
    assign stall         = r_stall;
    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_be        = r_mem_be;
    assign mem_wdata     = r_mem_wdata;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign resp_misalign = r_resp_mis;
    assign resp_err      = r_resp_err;

endmodule
